// File: rtl/irq_coalesce_pkg.sv
// Shared types, default widths and helpers for the irq_coalesce interrupt event coalescer.
package irq_coalesce_pkg;

  localparam int DefNumSrc = 72;
  localparam int DefCntW   = 8;
  localparam int DefTmrW   = 16;
  localparam int DefStatW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIRE  = 2'd2
  } chan_state_e;

  // Increment that sticks at the all-ones value of a 'width'-bit field (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/irq_coalesce_chan.sv
// One coalescing channel: IDLE/ACCUM/FIRE FSM with event counter, overflow counter and timeout timer.
// Fire statistics are built only when IRQ_COALESCE_STATS_EN is defined.
module irq_coalesce_chan
  import irq_coalesce_pkg::*;
#(
  parameter int CntW  = DefCntW,
  parameter int TmrW  = DefTmrW,
  parameter int StatW = DefStatW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt,
  input  logic             ack,
  input  logic             en,
  input  logic [CntW-1:0]  thresh,
  input  logic [TmrW-1:0]  timeout,
  output logic             irq,
  output logic [CntW-1:0]  pend_cnt,
  output logic [StatW-1:0] stats
);

  chan_state_e     state_reg, state_next;
  logic [CntW-1:0] cnt_reg, cnt_next;
  logic [CntW-1:0] ocnt_reg, ocnt_next;
  logic [TmrW-1:0] tmr_reg, tmr_next;
  logic [CntW-1:0] teff, cnt_inc, ocnt_inc, acc, oacc;
  logic [TmrW-1:0] to_eff;

  // A disabled channel behaves as threshold 1 with no timeout.
  assign teff     = (!en || thresh == '0) ? CntW'(1) : thresh;
  assign to_eff   = en ? timeout : '0;
  assign cnt_inc  = CntW'(sat_inc(32'(cnt_reg), CntW));
  assign ocnt_inc = CntW'(sat_inc(32'(ocnt_reg), CntW));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ocnt_reg  <= '0;
      tmr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ocnt_reg  <= ocnt_next;
      tmr_reg   <= tmr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ocnt_next  = ocnt_reg;
    tmr_next   = tmr_reg;
    acc        = cnt_reg;
    oacc       = ocnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (evt) begin
          cnt_next = CntW'(1);
          if (teff == CntW'(1)) begin
            state_next = ST_FIRE;
            ocnt_next  = '0;
          end else begin
            state_next = ST_ACCUM;
            tmr_next   = '0;
          end
        end
      end
      ST_ACCUM: begin
        tmr_next = tmr_reg + TmrW'(1);
        acc      = evt ? cnt_inc : cnt_reg;
        cnt_next = acc;
        if (acc >= teff || (to_eff != '0 && tmr_reg == to_eff - TmrW'(1))) begin
          state_next = ST_FIRE;
          ocnt_next  = '0;
        end
      end
      ST_FIRE: begin
        oacc      = evt ? ocnt_inc : ocnt_reg;
        ocnt_next = oacc;
        // Events that arrived while fired are carried into a fresh accumulation.
        if (ack) begin
          ocnt_next = '0;
          tmr_next  = '0;
          if (oacc == '0) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            state_next = ST_ACCUM;
            cnt_next   = oacc;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign irq      = (state_reg == ST_FIRE);
  assign pend_cnt = cnt_reg;

`ifdef IRQ_COALESCE_STATS_EN
  logic [StatW-1:0] stats_reg;
  logic             fire_enter;

  assign fire_enter = (state_reg != ST_FIRE) && (state_next == ST_FIRE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stats_reg <= '0;
    end else if (fire_enter) begin
      stats_reg <= StatW'(sat_inc(32'(stats_reg), StatW));
    end
  end

  assign stats = stats_reg;
`else
  assign stats = '0;
`endif

endmodule

// File: rtl/irq_coalesce.sv
// Per-source interrupt event coalescer; source 0 is reserved and tied off.
// Optional fire statistics: define IRQ_COALESCE_STATS_EN.
module irq_coalesce
  import irq_coalesce_pkg::*;
#(
  parameter int NumSrc = DefNumSrc,
  parameter int CntW   = DefCntW,
  parameter int TmrW   = DefTmrW,
  parameter int StatW  = DefStatW
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumSrc-1:0]       evt_i,
  input  logic [NumSrc-1:0]       ack_i,
  input  logic [NumSrc-1:0]       cfg_en_i,
  input  logic [CntW-1:0]         cfg_thresh_i,
  input  logic [TmrW-1:0]         cfg_timeout_i,
  output logic [NumSrc-1:0]       irq_o,
  output logic [NumSrc*CntW-1:0]  pend_cnt_o,
  output logic [NumSrc*StatW-1:0] stats_o
);

  logic unused_src0;

  assign unused_src0           = ^{evt_i[0], ack_i[0], cfg_en_i[0]};
  assign irq_o[0]              = 1'b0;
  assign pend_cnt_o[CntW-1:0]  = '0;
  assign stats_o[StatW-1:0]    = '0;

  for (genvar gi = 1; gi < NumSrc; gi++) begin : g_chan
    irq_coalesce_chan #(
      .CntW (CntW),
      .TmrW (TmrW),
      .StatW(StatW)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .evt     (evt_i[gi]),
      .ack     (ack_i[gi]),
      .en      (cfg_en_i[gi]),
      .thresh  (cfg_thresh_i),
      .timeout (cfg_timeout_i),
      .irq     (irq_o[gi]),
      .pend_cnt(pend_cnt_o[gi*CntW +: CntW]),
      .stats   (stats_o[gi*StatW +: StatW])
    );
  end

endmodule

// File: tb/tb_irq_coalesce.sv
// Scoreboard bench for irq_coalesce: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_coalesce;

  localparam int NS   = 72;
  localparam int CW   = 8;
  localparam int TW   = 16;
  localparam int SW   = 16;
  localparam int CMAX = 255;
  localparam int SMAX = 65535;
  localparam int PH_IDLE = 0, PH_ACC = 1, PH_FIRE = 2;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [NS-1:0]    evt_i, ack_i, cfg_en_i;
  logic [CW-1:0]    cfg_thresh_i;
  logic [TW-1:0]    cfg_timeout_i;
  logic [NS-1:0]    irq_o;
  logic [NS*CW-1:0] pend_cnt_o;
  logic [NS*SW-1:0] stats_o;

  irq_coalesce dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .evt_i        (evt_i),
    .ack_i        (ack_i),
    .cfg_en_i     (cfg_en_i),
    .cfg_thresh_i (cfg_thresh_i),
    .cfg_timeout_i(cfg_timeout_i),
    .irq_o        (irq_o),
    .pend_cnt_o   (pend_cnt_o),
    .stats_o      (stats_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic [NS-1:0]    irq;
    logic [NS*CW-1:0] pend;
    logic [NS*SW-1:0] stats;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Behavioural model: phase, pending count, overflow count, ACCUM entry cycle, fire count.
  int m_ph[NS], m_cnt[NS], m_ocnt[NS], m_start[NS], m_fires[NS];
  int mcyc = 0;

  task automatic model_step(input logic [NS-1:0] e, input logic [NS-1:0] a, input logic r);
    int teff, tov, age;
    bit fired;
    for (int s = 1; s < NS; s++) begin
      if (r) begin
        m_ph[s] = PH_IDLE; m_cnt[s] = 0; m_ocnt[s] = 0; m_fires[s] = 0;
      end else begin
        teff  = (cfg_en_i[s] && cfg_thresh_i != 0) ? int'(cfg_thresh_i) : 1;
        tov   = cfg_en_i[s] ? int'(cfg_timeout_i) : 0;
        fired = 1'b0;
        if (m_ph[s] == PH_IDLE) begin
          if (e[s]) begin
            m_cnt[s] = 1;
            if (teff == 1) fired = 1'b1;
            else begin
              m_ph[s] = PH_ACC; m_start[s] = mcyc + 1;
            end
          end
        end else if (m_ph[s] == PH_ACC) begin
          age = (mcyc - m_start[s]) % 65536;
          if (e[s]) m_cnt[s] = (m_cnt[s] < CMAX) ? m_cnt[s] + 1 : CMAX;
          if (m_cnt[s] >= teff || (tov != 0 && age == tov - 1)) fired = 1'b1;
        end else begin
          if (e[s] && m_ocnt[s] < CMAX) m_ocnt[s] = m_ocnt[s] + 1;
          if (a[s]) begin
            if (m_ocnt[s] == 0) begin
              m_ph[s] = PH_IDLE; m_cnt[s] = 0;
            end else begin
              m_ph[s] = PH_ACC; m_cnt[s] = m_ocnt[s]; m_ocnt[s] = 0; m_start[s] = mcyc + 1;
            end
          end
        end
        if (fired) begin
          m_ph[s] = PH_FIRE; m_ocnt[s] = 0;
          if (m_fires[s] < SMAX) m_fires[s] = m_fires[s] + 1;
        end
      end
    end
    mcyc = mcyc + 1;
  endtask

  // Drive one cycle of stimulus, queue the post-edge expectation, advance past the edge.
  task automatic tick(input logic [NS-1:0] e, input logic [NS-1:0] a, input logic r);
    exp_t x;
    evt_i = e; ack_i = a; rst_i = r;
    model_step(e, a, r);
    x.due = cyc + 1;
    for (int s = 0; s < NS; s++) begin
      x.irq[s] = (m_ph[s] == PH_FIRE);
      x.pend[s*CW +: CW] = CW'(m_cnt[s]);
`ifdef IRQ_COALESCE_STATS_EN
      x.stats[s*SW +: SW] = SW'(m_fires[s]);
`else
      x.stats[s*SW +: SW] = '0;
`endif
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    evt_i = '0; ack_i = '0; rst_i = 1'b0;
  endtask

  function automatic logic [NS-1:0] bit1(input int s);
    logic [NS-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, '0, 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Monitor: compares every cycle's DUT outputs against the queued expectation.
  initial begin
    exp_t x;
    int   bad;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        x = exp_q.pop_front();
        if (x.due != cyc) begin
          n_checks++; n_err++;
          $display("FAIL stale_expectation: due=%0d now=%0d", x.due, cyc);
        end else begin
          n_checks++;
          if (irq_o !== x.irq) begin
            n_err++;
            $display("FAIL irq cyc=%0d: got=%h expected=%h", cyc, irq_o, x.irq);
          end
          n_checks++;
          bad = -1;
          for (int s = NS - 1; s >= 0; s--)
            if (pend_cnt_o[s*CW +: CW] !== x.pend[s*CW +: CW]) bad = s;
          if (bad >= 0) begin
            n_err++;
            $display("FAIL pend cyc=%0d src=%0d: got=%0d expected=%0d", cyc, bad,
                     pend_cnt_o[bad*CW +: CW], x.pend[bad*CW +: CW]);
          end
          n_checks++;
          bad = -1;
          for (int s = NS - 1; s >= 0; s--)
            if (stats_o[s*SW +: SW] !== x.stats[s*SW +: SW]) bad = s;
          if (bad >= 0) begin
            n_err++;
            $display("FAIL stats cyc=%0d src=%0d: got=%0d expected=%0d", cyc, bad,
                     stats_o[bad*SW +: SW], x.stats[bad*SW +: SW]);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] e, a, en_all;
    int dens, ackp, t_exp;
    for (int s = 0; s < NS; s++) begin
      m_ph[s] = PH_IDLE; m_cnt[s] = 0; m_ocnt[s] = 0; m_start[s] = 0; m_fires[s] = 0;
    end
    en_all = '1;
    rst_i = 1'b1; evt_i = '0; ack_i = '0;
    cfg_en_i = en_all; cfg_thresh_i = CW'(4); cfg_timeout_i = '0;
    @(posedge clk); #1;

    // Reset state
    tick('0, '0, 1'b1); tick('0, '0, 1'b1); tick('0, '0, 1'b1);
    chk("reset_irq_any", int'(|irq_o), 0);
    chk("reset_pend_any", int'(|pend_cnt_o), 0);
    chk("reset_stats_any", int'(|stats_o), 0);
    $display("scenario reset done");

    // Bypass on source 5
    cfg_en_i = en_all; cfg_en_i[5] = 1'b0;
    idle(3);
    tick(bit1(5), '0, 1'b0);
    chk("bypass_irq_rise", int'(irq_o[5]), 1);
    idle(8);
    tick('0, bit1(5), 1'b0);
    chk("bypass_irq_fall", int'(irq_o[5]), 0);
    chk("bypass_pend_clear", int'(pend_cnt_o[5*CW +: CW]), 0);
    cfg_en_i = en_all;
    $display("scenario bypass done");

    // Threshold 4 on source 3, events at relative cycles 0,2,5,20
    cfg_thresh_i = CW'(4); cfg_timeout_i = '0;
    for (int c = 0; c <= 20; c++) begin
      tick((c == 0 || c == 2 || c == 5 || c == 20) ? bit1(3) : '0, '0, 1'b0);
      if (c == 19) chk("thresh_irq_before", int'(irq_o[3]), 0);
    end
    chk("thresh_irq_rise", int'(irq_o[3]), 1);
    chk("thresh_pend", int'(pend_cnt_o[3*CW +: CW]), 4);
    tick('0, bit1(3), 1'b0);
    $display("scenario threshold done");

    // Timeout 20 on source 7
    cfg_thresh_i = CW'(8); cfg_timeout_i = TW'(20);
    tick(bit1(7), '0, 1'b0);
    idle(19);
    chk("timeout_irq_before", int'(irq_o[7]), 0);
    idle(1);
    chk("timeout_irq_rise", int'(irq_o[7]), 1);
    chk("timeout_pend", int'(pend_cnt_o[7*CW +: CW]), 1);
    tick('0, bit1(7), 1'b0);
    $display("scenario timeout done");

    // Overflow requeue on source 9
    cfg_thresh_i = CW'(2); cfg_timeout_i = '0;
    tick(bit1(9), '0, 1'b0); tick(bit1(9), '0, 1'b0);
    chk("ovf_first_fire", int'(irq_o[9]), 1);
    tick(bit1(9), '0, 1'b0); tick(bit1(9), '0, 1'b0); tick(bit1(9), '0, 1'b0);
    tick('0, bit1(9), 1'b0);
    chk("ovf_ack_irq", int'(irq_o[9]), 0);
    chk("ovf_requeue_pend", int'(pend_cnt_o[9*CW +: CW]), 3);
    idle(1);
    chk("ovf_refire", int'(irq_o[9]), 1);
    tick(bit1(9), bit1(9), 1'b0);
    chk("ovf_ackevt_irq", int'(irq_o[9]), 0);
    chk("ovf_ackevt_pend", int'(pend_cnt_o[9*CW +: CW]), 1);
    idle(5);
    chk("ovf_no_refire", int'(irq_o[9]), 0);
    tick(bit1(9), '0, 1'b0);
    chk("ovf_second_fire", int'(irq_o[9]), 1);
    tick('0, bit1(9), 1'b0);
    $display("scenario overflow done");

    // Saturation on source 11
    cfg_thresh_i = CW'(255);
    for (int c = 1; c <= 300; c++) begin
      tick(bit1(11), '0, 1'b0);
      if (c == 254) chk("sat_irq_before", int'(irq_o[11]), 0);
      if (c == 255) chk("sat_irq_rise", int'(irq_o[11]), 1);
    end
    chk("sat_pend_hold", int'(pend_cnt_o[11*CW +: CW]), 255);
    tick('0, bit1(11), 1'b0);
    chk("sat_requeue_pend", int'(pend_cnt_o[11*CW +: CW]), 45);

    // Reset mid-operation and reserved source 0
    cfg_thresh_i = CW'(1);
    tick(bit1(2) | bit1(0), '0, 1'b0);
    chk("rst_pre_irq2", int'(irq_o[2]), 1);
    chk("src0_irq", int'(irq_o[0]), 0);
    tick(bit1(2) | bit1(0), '0, 1'b1);
    chk("rst_mid_irq_any", int'(|irq_o), 0);
    chk("rst_mid_pend_any", int'(|pend_cnt_o), 0);
    $display("scenario saturation/reset done");

    // Fire statistics on source 4
    for (int k = 0; k < 3; k++) begin
      tick(bit1(4), '0, 1'b0);
      tick('0, bit1(4), 1'b0);
    end
`ifdef IRQ_COALESCE_STATS_EN
    t_exp = 3;
`else
    t_exp = 0;
`endif
    chk("stats_src4", int'(stats_o[4*SW +: SW]), t_exp);
    $display("scenario stats done");

    // Randomized traffic with live configuration changes
    for (int ph = 0; ph < 15; ph++) begin
      cfg_en_i = NS'({$urandom(), $urandom(), $urandom()}) | NS'({$urandom(), $urandom(), $urandom()});
      case ($urandom_range(0, 5))
        0: cfg_thresh_i = CW'(0);
        1: cfg_thresh_i = CW'(1);
        2: cfg_thresh_i = CW'(2);
        3: cfg_thresh_i = CW'(3);
        4: cfg_thresh_i = CW'(6);
        default: cfg_thresh_i = CW'(255);
      endcase
      case ($urandom_range(0, 4))
        0: cfg_timeout_i = TW'(0);
        1: cfg_timeout_i = TW'(1);
        2: cfg_timeout_i = TW'(2);
        3: cfg_timeout_i = TW'(7);
        default: cfg_timeout_i = TW'(19);
      endcase
      dens = int'($urandom_range(1, 30));
      ackp = int'($urandom_range(2, 25));
      $display("phase %0d en=%h thresh=%0d timeout=%0d dens=%0d ackp=%0d",
               ph, cfg_en_i, cfg_thresh_i, cfg_timeout_i, dens, ackp);
      for (int c = 0; c < 200; c++) begin
        if (c == 100) cfg_thresh_i = CW'($urandom_range(0, 5));
        for (int s = 0; s < NS; s++) begin
          e[s] = (int'($urandom_range(0, 99)) < dens);
          a[s] = (int'($urandom_range(0, 99)) < ackp);
        end
        tick(e, a, (ph == 7 && c == 50));
      end
    end

    idle(3);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
